// File: rtl/genius_sequence_player.sv
// Plays back up to 16 captured two-bit symbols on a one-hot LED display, lighting each
// symbol for ON_TICKS cycles followed by an OFF_TICKS dark gap. All outputs are registered.
module genius_sequence_player #(
  parameter int unsigned ON_TICKS  = 25000000,
  parameter int unsigned OFF_TICKS = 12500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  length,
  input  logic [31:0] seq_flat,
  output logic [2:0]  leds,
  output logic [3:0]  step,
  output logic        busy,
  output logic        done,
  output logic        bad_symbol
);

  localparam int unsigned MaxTicks  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned TickWidth = $clog2(MaxTicks + 1);

  localparam logic [TickWidth-1:0] OnLast  = TickWidth'(ON_TICKS - 1);
  localparam logic [TickWidth-1:0] OffLast = TickWidth'(OFF_TICKS - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StOn     = 2'd1;
  localparam logic [1:0] StOff    = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [31:0]          shadow_q, shadow_d;
  logic [4:0]           count_q, count_d;
  logic [3:0]           step_q, step_d;
  logic [TickWidth-1:0] tick_q, tick_d;
  logic [2:0]           leds_q, leds_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bad_q, bad_d;
  logic [1:0]           symbol_d;

  // Next-state control: sequencing of steps and tick timing.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    step_d   = step_q;
    tick_d   = tick_q;
    bad_d    = bad_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d = seq_flat;
          count_d  = (length > 5'd16) ? 5'd16 : length;
          step_d   = 4'd0;
          tick_d   = '0;
          bad_d    = 1'b0;
          state_d  = (length != 5'd0) ? StOn : StFinish;
        end
      end
      StOn: begin
        if (tick_q == OnLast) begin
          tick_d  = '0;
          state_d = StOff;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StOff: begin
        if (tick_q == OffLast) begin
          tick_d = '0;
          if (({1'b0, step_q} + 5'd1) < count_q) begin
            step_d  = step_q + 4'd1;
            state_d = StOn;
          end else begin
            state_d = StFinish;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so that registered outputs line up with it.
  always_comb begin
    symbol_d = shadow_d[{step_d, 1'b0} +: 2];
    busy_d   = (state_d == StOn) || (state_d == StOff);
    done_d   = (state_d == StFinish);
    leds_d   = 3'b000;
    if (state_d == StOn) begin
      case (symbol_d)
        2'd0:    leds_d = 3'b001;
        2'd1:    leds_d = 3'b010;
        2'd2:    leds_d = 3'b100;
        default: leds_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      count_q  <= '0;
      step_q   <= '0;
      tick_q   <= '0;
      leds_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      step_q   <= step_d;
      tick_q   <= tick_d;
      leds_q   <= leds_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bad_q    <= bad_d | ((state_d == StOn) && (symbol_d == 2'd3));
    end
  end

  assign leds       = leds_q;
  assign step       = step_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bad_symbol = bad_q;

endmodule

// File: tb/tb_genius_sequence_player.sv
// Scoreboard bench: each playback pushes its expected per-cycle output frames, which are
// popped and compared cycle by cycle as the player runs.
module tb_genius_sequence_player;

  localparam int unsigned OnT  = 3;
  localparam int unsigned OffT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  length = '0;
  logic [31:0] seq_flat = '0;
  logic [2:0]  leds;
  logic [3:0]  step;
  logic        busy;
  logic        done;
  logic        bad_symbol;

  int total = 0;
  int bad = 0;

  // Frame layout: {leds[2:0], step[3:0], busy, done, bad_symbol}
  logic [9:0] sb_q[$];

  genius_sequence_player #(
    .ON_TICKS (OnT),
    .OFF_TICKS(OffT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .length    (length),
    .seq_flat  (seq_flat),
    .leds      (leds),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .bad_symbol(bad_symbol)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got leds=%b step=%0d busy=%b done=%b bad=%b, want leds=%b step=%0d busy=%b done=%b bad=%b",
               tag, got[9:7], got[6:3], got[2], got[1], got[0],
               exp[9:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [2:0] led_of(input logic [1:0] sym);
    case (sym)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [9:0] outs();
    return {leds, step, busy, done, bad_symbol};
  endfunction

  // disturb_at: frame index after which start is re-pulsed and seq_flat scrambled.
  // abort_at: frame index after which reset is asserted mid-playback.
  task automatic play(input string tag, input logic [31:0] seq, input logic [4:0] len,
                      input int disturb_at, input int abort_at);
    int n;
    logic sticky;
    logic [3:0] last;
    logic [1:0] sym;
    int idx;
    n = (len > 5'd16) ? 16 : int'(len);
    sticky = 1'b0;
    last = 4'd0;
    sb_q.delete();
    for (int s = 0; s < n; s++) begin
      sym = seq[2*s +: 2];
      if (sym == 2'd3) sticky = 1'b1;
      last = 4'(s);
      for (int t = 0; t < OnT; t++) sb_q.push_back({led_of(sym), last, 1'b1, 1'b0, sticky});
      for (int t = 0; t < OffT; t++) sb_q.push_back({3'b000, last, 1'b1, 1'b0, sticky});
    end
    sb_q.push_back({3'b000, last, 1'b0, 1'b1, sticky});
    sb_q.push_back({3'b000, last, 1'b0, 1'b0, sticky});

    @(negedge clock);
    seq_flat = seq;
    length = len;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    idx = 0;
    while (sb_q.size() > 0) begin
      check(tag, outs(), sb_q.pop_front());
      start = (idx == disturb_at);
      if (idx == disturb_at) begin
        seq_flat = ~seq;
        length = 5'd1;
      end
      if (idx == abort_at) begin
        #2 reset = 1'b1;
        #1 check({tag, "_rst_now"}, outs(), 10'd0);
        sb_q.delete();
        repeat (2) begin
          @(negedge clock);
          check({tag, "_rst_hold"}, outs(), 10'd0);
        end
        reset = 1'b0;
        @(negedge clock);
        check({tag, "_rst_idle"}, outs(), 10'd0);
        break;
      end
      idx++;
      if (sb_q.size() > 0) @(negedge clock);
    end
    start = 1'b0;
  endtask

  initial begin
    #1 check("reset_state", outs(), 10'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", outs(), 10'd0);

    // Symbols 0,1,2 over three steps.
    play("basic", 32'h0000_0024, 5'd3, -1, -1);
    // Zero-length playback goes straight to a done pulse.
    play("len0", 32'hFFFF_FFFF, 5'd0, -1, -1);
    // Length clamps to 16 steps; step tops out at 15.
    play("len20", 32'h5555_5555, 5'd20, -1, -1);
    // Symbol 3 at entry 1 darkens the LEDs and sets the sticky flag.
    play("bad_sym", 32'h0000_000C, 5'd2, -1, -1);
    // Next accepted start clears the sticky flag.
    play("clear_bad", 32'h0000_0002, 5'd1, -1, -1);
    // Start re-pulsed and seq_flat changed during step 0 ON must be ignored.
    play("no_restart", 32'h0000_0009, 5'd2, 1, -1);
    // Reset during step 1 OFF: frame 8 is the first OFF cycle of step 1.
    play("abort", 32'h0000_0016, 5'd3, -1, 8);
    // Fresh playback after abort starts from step 0.
    play("after_abort", 32'h0000_0021, 5'd3, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/genius_sequence_player.md
GENIUS_SEQUENCE_PLAYER -- requirements
Module: genius_sequence_player

Interface
REQ-001 Parameter ON_TICKS, default 25000000: clock cycles each step's LED is lit; legal minimum 1.
REQ-002 Parameter OFF_TICKS, default 12500000: clock cycles of dark gap after each step; legal minimum 1.
REQ-003 Port clock, input, 1: single clock; all state SHALL change on its rising edge, except on reset.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: request to begin playback; sampled only in IDLE.
REQ-006 Port length, input, 5: number of steps to play; sampled on the accepted start.
REQ-007 Port seq_flat, input, 32: 16 two-bit symbols; entry i occupies bits [2i+1:2i]; sampled on the accepted start.
REQ-008 Port leds, output, 3: one-hot display of the current symbol.
REQ-009 Port step, output, 4: index of the step being shown, for the 7-segment digit.
REQ-010 Port busy, output, 1: high while a playback is in progress.
REQ-011 Port done, output, 1: one-cycle pulse at the end of a playback.
REQ-012 Port bad_symbol, output, 1: sticky flag set when symbol 3 is played.

Function
REQ-013 The FSM SHALL have four states: IDLE, ON, OFF and FINISH, encoded in 2 bits.
REQ-014 In IDLE with start=1, the block SHALL capture seq_flat into a 32-bit shadow register.
REQ-015 In the same case it SHALL capture min(length,16) into a 5-bit count register.
REQ-016 It SHALL then clear bad_symbol and step, and move to ON next cycle (length>=1) or FINISH (length=0).
REQ-017 start SHALL be ignored in ON, OFF and FINISH; later changes to seq_flat or length SHALL not affect a playback in progress.
REQ-018 ON SHALL last exactly ON_TICKS cycles, timed by a tick counter wide enough for max(ON_TICKS,OFF_TICKS).
REQ-019 During ON: symbol 0 drives leds=3'b001, symbol 1 drives 3'b010, symbol 2 drives 3'b100.
REQ-020 During ON, symbol 3 SHALL drive leds=3'b000 and set bad_symbol=1.
REQ-021 OFF SHALL last exactly OFF_TICKS cycles with leds=3'b000.
REQ-022 At the end of OFF: if step+1 < count, step increments and the FSM returns to ON; otherwise it goes to FINISH.
REQ-023 step SHALL never wrap; the maximum value reached is 15, on a 16-step playback.
REQ-024 FINISH SHALL last one cycle with done=1, busy=0 and leds=0, then the FSM SHALL return to IDLE.
REQ-025 busy SHALL be 1 exactly in ON and OFF, and 0 otherwise.
REQ-026 A playback of N>=1 steps SHALL last N*(ON_TICKS+OFF_TICKS) busy cycles.
REQ-027 The first busy cycle SHALL be the cycle after start; done SHALL assert the cycle after the last busy cycle.
REQ-028 step SHALL hold its last value in FINISH and IDLE until the next accepted start.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 While reset=1, the state SHALL be IDLE, all counters and the shadow register 0, and leds=0, step=0, busy=0, done=0, bad_symbol=0.
REQ-031 This SHALL take effect immediately, independent of clock.
REQ-032 Reset asserted mid-playback SHALL abort the playback with no done pulse; the first start after reset release SHALL be accepted normally.

Verification (ON_TICKS=3, OFF_TICKS=2)
REQ-033 length=3, symbols 0,1,2, start pulse: leds=001x3, 000x2, 010x3, 000x2, 100x3, 000x2; step 0,1,2; busy 15 cycles; done on cycle 16.
REQ-034 length=0, start pulse: busy stays 0, leds stay 0, done=1 exactly one cycle after start.
REQ-035 length=20, all symbols 1: 16 steps played, step reaches 15 then holds, busy 80 cycles, single done pulse.
REQ-036 Symbol 3 at entry 1, length=2: leds=000 during step 1 ON, bad_symbol=1 from that cycle until the next accepted start.
REQ-037 start re-pulsed and seq_flat changed during ON: no restart, original symbols played, exactly one done.
REQ-038 Reset asserted during OFF of step 1, released two cycles later: outputs 0 immediately, no done; a new start then plays from step 0.
